// File: rtl/mem_port_arbiter.sv
// Request/acknowledge arbiter for the unified IF/MEM memory port.
// Loads and stores win over fetches until the starvation limit is reached.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int MAX_D_BURST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_read_part,
  input  logic [1:0]        d_write_part,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_read_part,
  output logic [1:0]        mem_write_part,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        owner
);

  localparam int CW =
    (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_D_BURST);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [2:0]        rpart_q;
  logic [1:0]        wpart_q;
  logic [CW-1:0]     d_cnt;

  logic arb;
  logic d_win;
  logic f_win;
  logic acc;

  logic unused;
  assign unused = ^{if_addr[31:ADDR_W], if_addr[1:0],
                    d_addr[31:ADDR_W]};

  // The requester being acked in RESP is masked so the other one gets a turn.
  always_comb begin
    arb   = (state == IDLE) || (state == RESP);
    d_win = arb && d_req
         && !(state == RESP && owner == OWN_D)
         && (!if_req || d_cnt < CNT_MAX);
    f_win = arb && if_req
         && !(state == RESP && owner == OWN_IF)
         && !d_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rpart_q  <= '0;
      wpart_q  <= '0;
      d_cnt    <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (!if_req || f_win) begin
        d_cnt <= '0;
      end else if (d_win && d_cnt != CNT_MAX) begin
        d_cnt <= d_cnt + 1'b1;
      end
      unique case (state)
        ACCESS: begin
          if (owner == OWN_IF) begin
            if_rdata <= mem_rdata;
          end else if (!we_q) begin
            d_rdata <= mem_rdata;
          end
          state <= RESP;
        end
        default: begin
          state <= ACCESS;
          unique case (1'b1)
            d_win: begin
              owner   <= OWN_D;
              addr_q  <= d_addr[ADDR_W-1:0];
              wdata_q <= d_wdata;
              we_q    <= d_we;
              rpart_q <= d_read_part;
              wpart_q <= d_write_part;
            end
            f_win: begin
              owner   <= OWN_IF;
              addr_q  <= {if_addr[ADDR_W-1:2], 2'b00};
              wdata_q <= '0;
              we_q    <= 1'b0;
              rpart_q <= 3'b010;
              wpart_q <= 2'b00;
            end
            default: begin
              state <= IDLE;
              owner <= OWN_NONE;
            end
          endcase
        end
      endcase
    end
  end

  // Port drive is decoded from state so an async reset drops it at once.
  assign acc            = (state == ACCESS);
  assign mem_addr       = acc ? addr_q : '0;
  assign mem_wdata      = acc ? wdata_q : '0;
  assign mem_read       = acc && !we_q;
  assign mem_write      = acc && we_q;
  assign mem_read_part  = acc ? rpart_q : '0;
  assign mem_write_part = acc ? wpart_q : '0;
  assign if_ack         = (state == RESP) && (owner == OWN_IF);
  assign d_ack          = (state == RESP) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences,
// and random traffic against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int MAXB = 3;

  typedef logic [7:0] bytes_t [256];

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rp;
    logic [1:0]  wp;
    logic [7:0]  e_maddr;
    logic [2:0]  e_rp;
    logic [31:0] e_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_read_part = '0;
  logic [1:0]  d_write_part = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_read_part;
  logic [1:0]  mem_write_part;
  logic [31:0] mem_rdata;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_read_part(d_read_part),
    .d_write_part(d_write_part),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_part(mem_read_part),
    .mem_write_part(mem_write_part),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  bytes_t      mem;
  bytes_t      ref_mem;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem_w;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d = '0;

  function automatic logic [31:0] get4(input bytes_t m,
                                       input logic [7:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = m[8'(a + i)];
    return w;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w,
                                           input logic [2:0] p);
    case (p)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] p);
    return (p == 2'b00) ? 1 : ((p == 2'b01) ? 2 : 4);
  endfunction

  // Behavioural memory on the port: combinational read, write at edge.
  always_comb begin
    mem_w = '0;
    for (int i = 0; i < 4; i++) mem_w[8*i +: 8] = mem[8'(mem_addr + i)];
    mem_rdata = load_val(mem_w, mem_read_part);
  end

  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++)
        mem[8'(pl_addr + i)] <= pl_data[8*i +: 8];
    end else if (mem_write) begin
      for (int i = 0; i < nbytes(mem_write_part); i++)
        mem[8'(mem_addr + i)] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[8'(a + i)] = d[8*i +: 8];
  endtask

  // One isolated request: grant at c0, ACCESS at c1, ack at c2.
  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr;
      d_wdata = v.wdata; d_read_part = v.rp;
      d_write_part = v.wp;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk("c0 port idle", {mem_read, mem_write}, 0);
    step();
    @(negedge clk);
    chk("acc mem_addr", mem_addr, v.e_maddr);
    chk("acc read_part", mem_read_part, v.e_rp);
    chk("acc mem_read", mem_read, !v.we);
    chk("acc mem_write", mem_write, v.we);
    chk("acc owner", owner, v.is_d ? 2 : 1);
    if (v.we) begin
      chk("acc write_part", mem_write_part, v.wp);
      chk("acc wdata", mem_wdata, v.wdata);
    end
    step();
    @(negedge clk);
    chk("resp if_ack", if_ack, !v.is_d);
    chk("resp d_ack", d_ack, v.is_d);
    chk("resp mem_read", mem_read, 0);
    if (!v.is_d) begin
      exp_if = v.e_rdata;
    end else if (!v.we) begin
      exp_d = v.e_rdata;
    end
    chk("resp if_rdata", if_rdata, exp_if);
    chk("resp d_rdata", d_rdata, exp_d);
    step();
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("after owner", owner, 0);
    chk("after acks", {if_ack, d_ack}, 0);
    step();
  endtask

  // Timeline model: who owns the port in which cycle, by the grant rules.
  int          t, arb_at, acc_t, who, cnt, msk;
  bit          dw, fw, in_acc, in_resp, pa_if, pa_d, if_act, d_act;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata;
  bit          c_we;
  logic [2:0]  c_rp;
  logic [1:0]  c_wp;
  logic [2:0]  rps [5];
  vec_t        vt [13];
  byte         got [8];
  int          n_got;

  initial begin
    rps = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst ctrl", {if_ack, d_ack, mem_read, mem_write, owner}, 0);
      chk("rst port", {mem_addr, mem_read_part, mem_write_part}, 0);
      chk("rst data", if_rdata | d_rdata | mem_wdata, 0);
    end
    step();

    preload(8'h00, 32'h00000013);
    preload(8'h04, 32'h00500093);
    preload(8'h10, 32'h80654321);
    preload(8'h20, 32'h11111111);

    vt[0]  = '{0, 0, 32'h06, 0, 3'b010, 0, 8'h04, 3'b010, 32'h00500093};
    vt[1]  = '{0, 0, 32'h107, 0, 3'b010, 0, 8'h04, 3'b010, 32'h00500093};
    vt[2]  = '{1, 0, 32'h13, 0, 3'b000, 0, 8'h13, 3'b000, 32'hFFFFFF80};
    vt[3]  = '{1, 0, 32'h13, 0, 3'b100, 0, 8'h13, 3'b100, 32'h00000080};
    vt[4]  = '{1, 0, 32'h12, 0, 3'b001, 0, 8'h12, 3'b001, 32'hFFFF8065};
    vt[5]  = '{1, 0, 32'h10, 0, 3'b010, 0, 8'h10, 3'b010, 32'h80654321};
    vt[6]  = '{1, 1, 32'h10, 32'hDEADBEEF, 3'b010, 2'b10,
               8'h10, 3'b010, 0};
    vt[7]  = '{1, 0, 32'h10, 0, 3'b010, 0, 8'h10, 3'b010, 32'hDEADBEEF};
    vt[8]  = '{1, 1, 32'h11, 32'h000000AA, 3'b000, 2'b00,
               8'h11, 3'b000, 0};
    vt[9]  = '{1, 0, 32'h10, 0, 3'b010, 0, 8'h10, 3'b010, 32'hDEADAAEF};
    vt[10] = '{1, 0, 32'h12, 0, 3'b101, 0, 8'h12, 3'b101, 32'h0000DEAD};
    vt[11] = '{1, 0, 32'hFFFFFF10, 0, 3'b010, 0,
               8'h10, 3'b010, 32'hDEADAAEF};
    vt[12] = '{1, 0, 32'h03, 0, 3'b001, 0, 8'h03, 3'b001, 32'hFFFF9300};
    for (int i = 0; i < 13; i++) run_vec(vt[i]);

    // Simultaneous requests: data first, then fetch
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10;
    d_wdata = 32'hDEADBEEF; d_read_part = 3'b010; d_write_part = 2'b10;
    @(negedge clk);
    step(); @(negedge clk);
    chk("sim c1 write", mem_write, 1);
    chk("sim c1 addr", mem_addr, 8'h10);
    chk("sim c1 owner", owner, 2);
    step(); @(negedge clk);
    chk("sim c2 acks", {if_ack, d_ack}, 2'b01);
    step(); d_req = 1'b0; @(negedge clk);
    chk("sim c3 read", {mem_read, mem_write}, 2'b10);
    chk("sim c3 addr", mem_addr, 8'h00);
    chk("sim c3 owner", owner, 1);
    step(); @(negedge clk);
    chk("sim c4 acks", {if_ack, d_ack}, 2'b10);
    chk("sim c4 rdata", if_rdata, 32'h00000013);
    exp_if = 32'h00000013;
    step(); if_req = 1'b0; @(negedge clk);
    chk("sim c5 owner", owner, 0);
    step();
    for (int i = 0; i < 4; i++) ref_mem[8'(8'h10 + i)] = 8'(32'hDEADBEEF >> (8*i));
    run_vec('{1, 0, 32'h10, 0, 3'b010, 0, 8'h10, 3'b010, 32'hDEADBEEF});

    // Both held: masking in RESP hands the port over, so acks alternate.
    if_req = 1'b1; if_addr = 32'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_read_part = 3'b010;
    n_got = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (if_ack && n_got < 8) begin got[n_got] = "i"; n_got++; end
      if (d_ack && n_got < 8) begin got[n_got] = "d"; n_got++; end
      step();
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("alt count", n_got, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt order %0d", i), got[i], (i % 2 == 0) ? "d" : "i");
    @(negedge clk);
    chk("alt late d_ack", d_ack, 1);
    step(); @(negedge clk);
    chk("alt drained", {owner, if_ack, d_ack}, 0);
    step();
    exp_if = 32'h00500093;
    exp_d = 32'hDEADBEEF;

    // Reset during the ACCESS cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
    d_wdata = 32'h22222222; d_write_part = 2'b10;
    @(negedge clk);
    step(); @(negedge clk);
    chk("rstw acc write", mem_write, 1);
    #1 rst = 1'b0;
    #1;
    chk("rstw write drop", mem_write, 0);
    chk("rstw owner", owner, 0);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    chk("rstw no ack", d_ack, 0);
    chk("rstw mem kept", get4(mem, 8'h20), 32'h11111111);
    step(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw idle", {owner, if_ack, d_ack, mem_read, mem_write}, 0);
      step();
    end
    exp_if = '0;
    exp_d = '0;

    // Random traffic against the model
    t = 0; arb_at = 0; acc_t = -5; who = 0; cnt = 0;
    pa_if = 0; pa_d = 0; if_act = 0; d_act = 0;
    c_addr = '0; c_wdata = '0; c_we = 0; c_rp = '0; c_wp = '0;
    for (int k = 0; k < 3000; k++) begin
      if (pa_if || !if_act) begin
        if_act = ($urandom_range(0, 99) < 60);
        if (if_act) if_addr = $urandom;
      end
      if (pa_d || !d_act) begin
        d_act = ($urandom_range(0, 99) < 60);
        if (d_act) begin
          d_we = $urandom_range(0, 2) == 0;
          d_addr = $urandom;
          d_wdata = $urandom;
          d_read_part = rps[$urandom_range(0, 4)];
          d_write_part = 2'($urandom_range(0, 2));
        end
      end
      if_req = if_act;
      d_req = d_act;
      in_acc = (t == acc_t);
      in_resp = (t == acc_t + 1);
      @(negedge clk);
      chk("rnd if_ack", if_ack, in_resp && who == 1);
      chk("rnd d_ack", d_ack, in_resp && who == 2);
      chk("rnd owner", owner, (in_acc || in_resp) ? who : 0);
      chk("rnd mem_read", mem_read, in_acc && !c_we);
      chk("rnd mem_write", mem_write, in_acc && c_we);
      chk("rnd mem_addr", mem_addr, in_acc ? c_addr : 0);
      chk("rnd read_part", mem_read_part, in_acc ? c_rp : 0);
      chk("rnd write_part", mem_write_part, in_acc ? c_wp : 0);
      if (in_acc && c_we) chk("rnd wdata", mem_wdata, c_wdata);
      chk("rnd if_rdata", if_rdata, exp_if);
      chk("rnd d_rdata", d_rdata, exp_d);
      pa_if = in_resp && who == 1;
      pa_d = in_resp && who == 2;
      if (in_acc) begin
        if (who == 1) begin
          exp_if = get4(ref_mem, c_addr);
        end else if (!c_we) begin
          exp_d = load_val(get4(ref_mem, c_addr), c_rp);
        end else begin
          for (int i = 0; i < nbytes(c_wp); i++)
            ref_mem[8'(c_addr + i)] = c_wdata[8*i +: 8];
        end
      end
      dw = 0;
      fw = 0;
      if (t == arb_at) begin
        msk = in_resp ? who : 0;
        dw = d_req && msk != 2 && (!if_req || cnt < MAXB);
        fw = !dw && if_req && msk != 1;
        arb_at = t + 1;
      end
      if (dw) begin
        who = 2; c_addr = d_addr[7:0]; c_wdata = d_wdata;
        c_we = d_we; c_rp = d_read_part; c_wp = d_write_part;
      end else if (fw) begin
        who = 1; c_addr = {if_addr[7:2], 2'b00}; c_wdata = '0;
        c_we = 0; c_rp = 3'b010; c_wp = 2'b00;
      end
      if (dw || fw) begin
        acc_t = t + 1;
        arb_at = t + 2;
      end
      if (!if_req || fw) cnt = 0;
      else if (dw && cnt < MAXB) cnt++;
      t++;
      step();
    end
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
